// File: rtl/game_timer_bcd.sv
// Parametrised BCD countdown round timer with pause, restart and bonus add.
// Optional low-time warn output enabled by defining GAME_TIMER_WARN_EN.
module game_timer_bcd #(
  parameter int                    DIGITS    = 2,
  parameter logic [4*DIGITS-1:0]   START_BCD = 8'h20,
  parameter logic [4*DIGITS-1:0]   WARN_BCD  = 8'h05
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  add_en,
  input  logic [4*DIGITS-1:0]   add_bcd,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  playing,
  output logic                  paused,
  output logic                  expired
`ifdef GAME_TIMER_WARN_EN
  ,
  output logic                  warn
`endif
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   digits_q, digits_d;
  logic           playing_q, playing_d;
  logic           paused_q, paused_d;
  logic           expired_q, expired_d;
  logic [W-1:0]   sum;

  function automatic logic [W-1:0] bcd_add_sat(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] r;
    logic [3:0]   bn;
    logic [4:0]   s;
    logic         c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bn = (b[4*i+:4] > 4'd9) ? 4'd9 : b[4*i+:4];
      s  = {1'b0, a[4*i+:4]} + {1'b0, bn} + {4'b0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i+:4] = s[3:0];
    end
    if (c) r = {DIGITS{4'h9}};
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] a);
    logic [W-1:0] r;
    logic         bw;
    r  = a;
    bw = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bw) begin
        if (a[4*i+:4] == 4'd0) begin
          r[4*i+:4] = 4'd9;
        end else begin
          r[4*i+:4] = a[4*i+:4] - 4'd1;
          bw = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state: start beats pause, pause beats add/tick.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    expired_d = 1'b0;
    sum       = add_en ? bcd_add_sat(digits_q, add_bcd) : digits_q;
    if (start) begin
      state_d  = S_RUN;
      digits_d = START_BCD;
    end else if (pause && state_q != S_DONE) begin
      state_d = (state_q == S_RUN) ? S_PAUSED : S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (!tick) begin
            digits_d = sum;
          end else if (sum == '0) begin
            state_d   = S_DONE;
            digits_d  = '0;
            expired_d = 1'b1;
          end else begin
            digits_d = bcd_dec(sum);
          end
        end
        S_PAUSED: digits_d = sum;
        default:  digits_d = '0;
      endcase
    end
    playing_d = (state_d != S_DONE);
    paused_d  = (state_d == S_PAUSED);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_RUN;
      digits_q  <= START_BCD;
      playing_q <= 1'b1;
      paused_q  <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      playing_q <= playing_d;
      paused_q  <= paused_d;
      expired_q <= expired_d;
    end
  end

  assign digits  = digits_q;
  assign playing = playing_q;
  assign paused  = paused_q;
  assign expired = expired_q;

`ifdef GAME_TIMER_WARN_EN
  logic warn_q, warn_d;

  // Low-time flag follows the digits being loaded this edge.
  always_comb begin
    warn_d = (state_d != S_DONE) && (digits_d <= WARN_BCD);
  end

  // Warn register.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) warn_q <= 1'b0;
    else       warn_q <= warn_d;
  end

  assign warn = warn_q;
`else
  logic unused_warn;
  assign unused_warn = ^WARN_BCD;
`endif

endmodule
